// File: rtl/region_mask_stream.sv
// region_mask_stream: streaming pixel filter that masks up to NUM_REGIONS rectangles
// with fill, horizontal mosaic or invert, config double-buffered and committed on EOP.
module region_mask_stream #(
    parameter int DW          = 16,
    parameter int FRAME_W     = 320,
    parameter int FRAME_H     = 240,
    parameter int NUM_REGIONS = 4,
    parameter int TILE        = 8,
    parameter int AW          = $clog2(2 * NUM_REGIONS + 2)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic          out_valid,
    input  logic          out_ready,
    input  logic          cfg_wr,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic          frame_err
);
    localparam int N = NUM_REGIONS;
    localparam int TW = $clog2(TILE);
    localparam logic [AW-1:0] MODE_A = AW'(2 * N);
    localparam logic [AW-1:0] FILL_A = AW'(2 * N + 1);
    localparam logic [15:0] X_MAX = 16'(FRAME_W - 1);
    localparam logic [15:0] Y_MAX = 16'(FRAME_H - 1);

    logic [2*N-1:0][31:0] sh_xy_q, sh_xy_d, act_xy_q, act_xy_d;
    logic [2*N-1:0] sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
    logic [DW-1:0] sh_fill_q, sh_fill_d, act_fill_q, act_fill_d;
    logic [15:0] x_q, x_d, y_q, y_d, px, py, win_x0;
    logic frame_active_q, frame_active_d, frame_err_q, frame_err_d;
    logic [DW-1:0] hold_q, hold_d, pix, out_data_q, out_data_d;
    logic out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic acc, in_frame, cap, commit;
    logic [1:0] win_mode;

    assign in_ready = ~out_valid_q | out_ready;
    assign acc = in_valid & in_ready;
    assign commit = acc & in_eop;
    assign in_frame = in_sop | frame_active_q;
    assign px = in_sop ? '0 : x_q;
    assign py = in_sop ? '0 : y_q;
    assign out_data = out_data_q;
    assign out_sop = out_sop_q;
    assign out_eop = out_eop_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

    // Shadow takes its pre-write value into active, so a same-cycle write lands a frame later
    always_comb begin
        sh_xy_d = sh_xy_q;
        for (int i = 0; i < 2 * N; i++)
            if (cfg_wr && cfg_addr == AW'(i)) sh_xy_d[i] = cfg_wdata;
        sh_mode_d = (cfg_wr && cfg_addr == MODE_A) ? cfg_wdata[2*N-1:0] : sh_mode_q;
        sh_fill_d = (cfg_wr && cfg_addr == FILL_A) ? cfg_wdata[DW-1:0] : sh_fill_q;
        act_xy_d = commit ? sh_xy_q : act_xy_q;
        act_mode_d = commit ? sh_mode_q : act_mode_q;
        act_fill_d = commit ? sh_fill_q : act_fill_q;
    end

    // Descending scan so the lowest-index enabled region wins
    always_comb begin
        win_mode = 2'b00;
        win_x0 = '0;
        for (int r = N - 1; r >= 0; r--)
            if (in_frame && act_mode_q[2*r+:2] != 2'b00 &&
                px >= act_xy_q[2*r][15:0] && px <= act_xy_q[2*r][31:16] &&
                py >= act_xy_q[2*r+1][15:0] && py <= act_xy_q[2*r+1][31:16]) begin
                win_mode = act_mode_q[2*r+:2];
                win_x0 = act_xy_q[2*r][15:0];
            end
        cap = (px == win_x0) || (px[TW-1:0] == '0);
        pix = win_mode == 2'b01 ? act_fill_q :
              win_mode == 2'b11 ? ~in_data :
              (win_mode == 2'b10 && !cap) ? hold_q : in_data;
        hold_d = (acc && win_mode == 2'b10 && cap) ? in_data : hold_q;
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        frame_active_d = frame_active_q;
        frame_err_d = frame_err_q | (acc & in_sop & frame_active_q);
        if (acc && in_eop) begin
            x_d = '0;
            y_d = '0;
            frame_active_d = 1'b0;
            frame_err_d = frame_err_d | (px != X_MAX) | (py != Y_MAX);
        end else if (acc && in_frame) begin
            frame_active_d = 1'b1;
            x_d = px == X_MAX ? '0 : px + 16'd1;
            y_d = px != X_MAX ? py : py == Y_MAX ? py : py + 16'd1;
            frame_err_d = frame_err_d | (px == X_MAX && py == Y_MAX);
        end
    end

    always_comb begin
        out_valid_d = in_ready ? in_valid : out_valid_q;
        out_data_d = acc ? pix : out_data_q;
        out_sop_d = acc ? in_sop : out_sop_q;
        out_eop_d = acc ? in_eop : out_eop_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_xy_q <= '0;
            sh_mode_q <= '0;
            sh_fill_q <= '0;
            act_xy_q <= '0;
            act_mode_q <= '0;
            act_fill_q <= '0;
            x_q <= '0;
            y_q <= '0;
            frame_active_q <= 1'b0;
            frame_err_q <= 1'b0;
            hold_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sop_q <= 1'b0;
            out_eop_q <= 1'b0;
        end else begin
            sh_xy_q <= sh_xy_d;
            sh_mode_q <= sh_mode_d;
            sh_fill_q <= sh_fill_d;
            act_xy_q <= act_xy_d;
            act_mode_q <= act_mode_d;
            act_fill_q <= act_fill_d;
            x_q <= x_d;
            y_q <= y_d;
            frame_active_q <= frame_active_d;
            frame_err_q <= frame_err_d;
            hold_q <= hold_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_sop_q <= out_sop_d;
            out_eop_q <= out_eop_d;
        end
    end
endmodule

// File: tb/tb_region_mask_stream.sv
// tb_region_mask_stream: directed probe table plus randomized scoreboard against a
// frame-level reference model of region_mask_stream (reduced frame size for run time).
module tb_region_mask_stream;
    localparam int W = 64, H = 16, N = 4, T = 8, AW = 4;

    logic clk = 1'b0;
    logic reset, in_sop, in_eop, in_valid, in_ready, out_sop, out_eop, out_valid, out_ready;
    logic cfg_wr, frame_err;
    logic [15:0] in_data, out_data;
    logic [AW-1:0] cfg_addr;
    logic [31:0] cfg_wdata;

    always #5 clk = ~clk;

    region_mask_stream #(.DW(16), .FRAME_W(W), .FRAME_H(H), .NUM_REGIONS(N), .TILE(T)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready), .cfg_wr(cfg_wr),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .frame_err(frame_err)
    );

    typedef struct {
        logic [15:0] d;
        logic s;
        logic e;
        int cyc;
        int tag;
        int x;
        int y;
    } exp_t;
    typedef struct {
        int f;
        int x;
        int y;
        logic [15:0] e;
    } probe_t;

    int checks = 0, passed = 0;
    exp_t q[$];
    exp_t e_pop;
    probe_t probes[$];
    int a_x0[N], a_x1[N], a_y0[N], a_y1[N], s_x0[N], s_x1[N], s_y0[N], s_y1[N];
    logic [1:0] a_mode[N], s_mode[N];
    logic [15:0] a_fill, s_fill, ed, sv_d;
    logic [15:0] m_line[W];
    logic [15:0] img[4][H][W];
    bit m_fa, m_err, lat_chk, zb_chk, stall_en, prev_stall, sv_s, sv_e;
    int m_n, mx, my, cyc = 0, last_in = 0, cur_tag = -1, ra;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: first enabled region containing (x,y) decides; mosaic repeats the
    // input pixel at the start of its tile, clipped to the region's left edge.
    function automatic logic [15:0] model_pix(int x, int y, logic [15:0] d);
        for (int r = 0; r < N; r++)
            if (a_mode[r] != 2'd0 && x >= a_x0[r] && x <= a_x1[r] && y >= a_y0[r] && y <= a_y1[r])
                return a_mode[r] == 2'd1 ? a_fill : a_mode[r] == 2'd3 ? ~d :
                       m_line[(x - x % T) > a_x0[r] ? (x - x % T) : a_x0[r]];
        return d;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            m_fa = 0;
            m_n = 0;
            m_err = 0;
            prev_stall = 0;
            for (int r = 0; r < N; r++) begin
                a_x0[r] = 0; a_x1[r] = 0; a_y0[r] = 0; a_y1[r] = 0; a_mode[r] = 0;
                s_x0[r] = 0; s_x1[r] = 0; s_y0[r] = 0; s_y1[r] = 0; s_mode[r] = 0;
            end
            a_fill = 0;
            s_fill = 0;
        end else begin
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
            if (prev_stall)
                chk("stall_hold", {13'd0, out_valid, out_sop, out_eop, out_data}, {13'd0, 1'b1, sv_s, sv_e, sv_d});
            prev_stall = out_valid && !out_ready;
            sv_d = out_data;
            sv_s = out_sop;
            sv_e = out_eop;
            if (out_valid && out_ready) begin
                chk("out_beat_queued", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e_pop = q.pop_front();
                    chk("out_data", {16'd0, out_data}, {16'd0, e_pop.d});
                    chk("out_sop_eop", {30'd0, out_sop, out_eop}, {30'd0, e_pop.s, e_pop.e});
                    if (lat_chk) chk("latency", cyc - e_pop.cyc, 32'd1);
                    if (e_pop.tag >= 0) img[e_pop.tag][e_pop.y][e_pop.x] = out_data;
                end
            end
            if (in_valid && in_ready) begin
                if (in_sop) begin
                    if (m_fa) m_err = 1;
                    m_fa = 1;
                    m_n = 0;
                end
                mx = m_n % W;
                my = m_n / W;
                if (m_fa) begin
                    m_line[mx] = in_data;
                    ed = model_pix(mx, my, in_data);
                end else ed = in_data;
                q.push_back('{ed, in_sop, in_eop, cyc, m_fa ? cur_tag : -1, mx, my});
                if (zb_chk && !in_sop) chk("zero_bubble", cyc - last_in, 32'd1);
                last_in = cyc;
                if (in_eop) begin
                    if (m_n != W * H - 1) m_err = 1;
                    m_fa = 0;
                    m_n = 0;
                    a_x0 = s_x0; a_x1 = s_x1; a_y0 = s_y0; a_y1 = s_y1; a_mode = s_mode; a_fill = s_fill;
                end else if (m_fa) m_n++;
            end
            if (cfg_wr) begin
                ra = int'(cfg_addr);
                if (ra < 2 * N && ra % 2 == 0) begin
                    s_x0[ra/2] = int'(cfg_wdata[15:0]);
                    s_x1[ra/2] = int'(cfg_wdata[31:16]);
                end else if (ra < 2 * N) begin
                    s_y0[ra/2] = int'(cfg_wdata[15:0]);
                    s_y1[ra/2] = int'(cfg_wdata[31:16]);
                end else if (ra == 2 * N) begin
                    for (int r = 0; r < N; r++) s_mode[r] = cfg_wdata[2*r+:2];
                end else if (ra == 2 * N + 1) s_fill = cfg_wdata[15:0];
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send(input logic [15:0] d, input logic s, input logic e);
        in_data = d;
        in_sop = s;
        in_eop = e;
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_sop = 1'b0;
                in_eop = 1'b0;
                return;
            end
        end
        checks++;
        $display("FAIL accept_timeout: beat not accepted within 100 cycles");
        in_valid = 1'b0;
    endtask

    task automatic cfg(input int a, input logic [31:0] d);
        cfg_wr = 1'b1;
        cfg_addr = AW'(a);
        cfg_wdata = d;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic run_frame(input int pat, input int tag, input bit gaps, input bit eop_wr,
                             input int wa, input logic [31:0] wd);
        logic [15:0] d;
        bit last;
        cur_tag = tag;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                d = pat == 0 ? 16'(x + y) : pat == 1 ? 16'((y << 8) | x) : 16'($urandom);
                if (gaps && $urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
                last = (x == W - 1) && (y == H - 1);
                if (last && eop_wr) begin
                    cfg_wr = 1'b1;
                    cfg_addr = AW'(wa);
                    cfg_wdata = wd;
                end
                send(d, x == 0 && y == 0, last);
                cfg_wr = 1'b0;
            end
        cur_tag = -1;
    endtask

    initial begin
        int cnt;
        probes.push_back('{1, 10, 5, 16'hF800}); probes.push_back('{1, 19, 6, 16'hF800});
        probes.push_back('{1, 9, 5, 16'h0509});  probes.push_back('{1, 20, 6, 16'h0614});
        probes.push_back('{1, 10, 4, 16'h040A}); probes.push_back('{1, 15, 7, 16'h070F});
        probes.push_back('{1, 2, 0, 16'h0002});  probes.push_back('{1, 3, 0, 16'h0003});
        probes.push_back('{1, 7, 0, 16'h0003});  probes.push_back('{1, 8, 0, 16'h0008});
        probes.push_back('{1, 15, 0, 16'h0008}); probes.push_back('{1, 16, 0, 16'h0010});
        probes.push_back('{1, 20, 0, 16'h0010}); probes.push_back('{1, 21, 0, 16'h0015});
        probes.push_back('{1, 5, 1, 16'h0105});
        probes.push_back('{2, 50, 10, 16'hF800}); probes.push_back('{2, 45, 8, 16'hF800});
        probes.push_back('{2, 52, 11, 16'hF800}); probes.push_back('{2, 53, 10, 16'hF5CA});
        probes.push_back('{2, 60, 12, 16'hF3C3}); probes.push_back('{2, 61, 12, 16'h0C3D});
        probes.push_back('{2, 44, 8, 16'h082C});  probes.push_back('{2, 10, 5, 16'h050A});
        probes.push_back('{2, 7, 0, 16'h0007});
        probes.push_back('{3, 50, 10, 16'hF5CD}); probes.push_back('{3, 45, 8, 16'h082D});
        probes.push_back('{3, 53, 10, 16'hF5CA});
        reset = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sop = 1'b0; in_eop = 1'b0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        lat_chk = 0; zb_chk = 0; stall_en = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        // Region0 fill and region1 mosaic, committed at frame A's EOP
        cfg(0, 32'h0013_000A); cfg(1, 32'h0006_0005); cfg(2, 32'h0014_0003); cfg(3, 32'h0);
        cfg(8, 32'h9); cfg(9, 32'hF800);
        lat_chk = 1;
        zb_chk = 1;
        run_frame(0, 0, 0, 0, 0, 0);
        zb_chk = 0;
        chk("err_after_frame_a", {31'd0, frame_err}, 32'd0);
        // Overlapping fill (r0) and invert (r2); mode rewritten on frame B's EOP
        cfg(0, 32'h0034_002D); cfg(1, 32'h000B_0008); cfg(4, 32'h003C_0032); cfg(5, 32'h000C_000A);
        cfg(8, 32'h31);
        run_frame(1, 1, 0, 1, 8, 32'h30);
        run_frame(1, 2, 0, 0, 0, 0);
        for (int r = 0; r < N; r++) begin
            cfg(2 * r, {16'($urandom_range(0, W - 1)), 16'($urandom_range(0, W - 1))});
            cfg(2 * r + 1, {16'(4 * r + $urandom_range(0, 3)), 16'(4 * r + $urandom_range(0, 3))});
        end
        cfg(8, $urandom);
        cfg(9, $urandom);
        for (int a = 2 * N + 2; a < 16; a++) cfg(a, $urandom);
        run_frame(1, 3, 0, 0, 0, 0);
        lat_chk = 0;
        stall_en = 1;
        run_frame(2, -1, 1, 0, 0, 0);
        stall_en = 0;
        repeat (4) @(posedge clk);
        #1;
        foreach (probes[i])
            chk($sformatf("probe_f%0d_(%0d,%0d)", probes[i].f, probes[i].x, probes[i].y),
                {16'd0, img[probes[i].f][probes[i].y][probes[i].x]}, {16'd0, probes[i].e});
        cnt = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) if (img[1][y][x] == 16'hF800) cnt++;
        chk("fill_pixel_count", cnt, 32'd20);
        chk("err_after_clean_frames", {31'd0, frame_err}, 32'd0);
        // Early EOP at (40,3), stray beats, then SOP twice
        for (int n = 0; n <= 3 * W + 40; n++) send(16'($urandom), n == 0, n == 3 * W + 40);
        chk("err_after_early_eop", {31'd0, frame_err}, 32'd1);
        repeat (3) send(16'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int n = 0; n < 6; n++) send(16'($urandom), n == 0, 1'b0);
        chk("err_sticky", {31'd0, frame_err}, 32'd1);
        in_data = 16'h1234;
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midframe_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midframe_rst_err", {31'd0, frame_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        for (int n = 0; n < 4; n++) send(16'(16'hA000 + n), 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_after_reset", {31'd0, frame_err}, 32'd0);
        chk("queue_drained", q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
